// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one 6-bit arithmetic right shifter
// between two ALU requesters, with latched operands and a registered result.

// Shared 6-bit arithmetic right shifter (combinational).
module shift_unit (
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic [5:0] y_c
);

  // Out-of-range amounts (b >= 8) saturate to pure sign fill.
  always_comb begin
    y_c = '0;
    if (|b[5:3]) begin
      y_c = {6{a[5]}};
    end else begin
      y_c = 6'($signed(a) >>> b[2:0]);
    end
  end

endmodule

module shift_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [5:0] a0,
  input  logic [5:0] b0,
  input  logic       req1,
  input  logic [5:0] a1,
  input  logic [5:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [5:0] result,
  output logic       busy
);

  localparam int unsigned W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, nxt_state;
  logic           owner, nxt_owner;
  logic           last, nxt_last;
  logic [W-1:0]   op_a, nxt_op_a;
  logic [W-1:0]   op_b, nxt_op_b;
  logic [W-1:0]   nxt_result;
  logic           nxt_gnt0, nxt_gnt1, nxt_done0, nxt_done1, nxt_busy;
  logic           win;
  logic [W-1:0]   shift_y_c;

  shift_unit u_shift (
    .a   (op_a),
    .b   (op_b),
    .y_c (shift_y_c)
  );

  // State, operand latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= nxt_state;
      owner  <= nxt_owner;
      last   <= nxt_last;
      op_a   <= nxt_op_a;
      op_b   <= nxt_op_b;
      result <= nxt_result;
      gnt0   <= nxt_gnt0;
      gnt1   <= nxt_gnt1;
      done0  <= nxt_done0;
      done1  <= nxt_done1;
      busy   <= nxt_busy;
    end
  end

  // Next-state, arbitration and output decode from the next state/owner.
  always_comb begin
    nxt_state  = state;
    nxt_owner  = owner;
    nxt_last   = last;
    nxt_op_a   = op_a;
    nxt_op_b   = op_b;
    nxt_result = result;
    win        = 1'b0;

    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          win       = (req0 && req1) ? ~last : req1;
          nxt_owner = win;
          nxt_last  = win;
          nxt_op_a  = win ? a1 : a0;
          nxt_op_b  = win ? b1 : b0;
          nxt_state = BUSY;
        end
      end
      BUSY: begin
        nxt_result = shift_y_c;
        nxt_state  = RESP;
      end
      RESP: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    nxt_busy  = (nxt_state != IDLE);
    nxt_gnt0  = nxt_busy && !nxt_owner;
    nxt_gnt1  = nxt_busy && nxt_owner;
    nxt_done0 = (nxt_state == RESP) && !nxt_owner;
    nxt_done1 = (nxt_state == RESP) && nxt_owner;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, hand-built
// multi-cycle sequences and randomized transactions against a reference model.
module tb_shift_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [5:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [5:0] result;

  int nvec  = 0;
  int nfail = 0;
  logic last_m = 1'b1;

  shift_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       which;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Floor division of the signed operand by 2**b.
  function automatic logic [5:0] ref_shift(input logic [5:0] a, input logic [5:0] b);
    int sa, d, q;
    sa = a[5] ? int'(a) - 64 : int'(a);
    if (int'(b) >= 6) return (sa < 0) ? 6'h3F : 6'h00;
    d = 1 << int'(b);
    q = sa / d;
    if (sa < 0 && q * d != sa) q = q - 1;
    return 6'(q);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec = nvec + 1;
    if (act != exp) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".gnt0"}, int'(gnt0), 0);
    chk({tag, ".gnt1"}, int'(gnt1), 0);
    chk({tag, ".done0"}, int'(done0), 0);
    chk({tag, ".done1"}, int'(done1), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
  endtask

  // One full transaction, entered and left at an IDLE-cycle negedge.
  task automatic run_op(input logic r0, input logic r1,
                        input logic [5:0] ia0, input logic [5:0] ib0,
                        input logic [5:0] ia1, input logic [5:0] ib1,
                        input logic exp_own, input logic [5:0] exp_res,
                        input logic mess, input string tag);
    req0 = r0; req1 = r1; a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
    @(negedge clk);
    chk({tag, ".b_busy"}, int'(busy), 1);
    chk({tag, ".b_gnt0"}, int'(gnt0), int'(!exp_own));
    chk({tag, ".b_gnt1"}, int'(gnt1), int'(exp_own));
    chk({tag, ".b_done"}, int'(done0 | done1), 0);
    if (mess) begin
      a0 = 6'h3F; b0 = 6'h00; a1 = 6'h3F; b1 = 6'h00;
      req0 = 1'b0; req1 = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".r_busy"}, int'(busy), 1);
    chk({tag, ".r_gnt0"}, int'(gnt0), int'(!exp_own));
    chk({tag, ".r_done0"}, int'(done0), int'(!exp_own));
    chk({tag, ".r_done1"}, int'(done1), int'(exp_own));
    chk({tag, ".result"}, int'(result), int'(exp_res));
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk_idle({tag, ".i"});
    last_m = exp_own;
  endtask

  initial begin
    logic [5:0] ra0, rb0, ra1, rb1, keep;
    logic       r0, r1, own;
    int         r;

    vecs[0] = '{1'b0, 6'b101100, 6'd2,       6'b111011};
    vecs[1] = '{1'b1, 6'b011000, 6'd3,       6'b000011};
    vecs[2] = '{1'b1, 6'b100001, 6'b001001,  6'b111111};
    vecs[3] = '{1'b1, 6'b010101, 6'd0,       6'b010101};
    vecs[4] = '{1'b0, 6'b011111, 6'd5,       6'b000000};
    vecs[5] = '{1'b0, 6'b100000, 6'd5,       6'b111111};
    vecs[6] = '{1'b1, 6'b100000, 6'd4,       6'b111110};
    vecs[7] = '{1'b0, 6'b010000, 6'd7,       6'b000000};
    vecs[8] = '{1'b1, 6'b011111, 6'd1,       6'b001111};
    vecs[9] = '{1'b0, 6'b110101, 6'b100000,  6'b111111};

    do_reset();
    chk_idle("reset");
    chk("reset.result", int'(result), 0);

    // Directed single-requester vectors.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].which)
        run_op(1'b0, 1'b1, 6'h15, 6'h00, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
      else
        run_op(1'b1, 1'b0, vecs[i].a, vecs[i].b, 6'h2A, 6'h00, 1'b0, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Both requesters held continuously from reset: grants alternate 0,1,0,1.
    do_reset();
    a0 = 6'b100110; b0 = 6'd1; a1 = 6'b011011; b1 = 6'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      own = 1'((c / 3) % 2);
      chk("rr.excl", int'(gnt0 & gnt1), 0);
      chk("rr.dexcl", int'(done0 & done1), 0);
      case (c % 3)
        0: begin
          chk("rr.busy", int'(busy), 1);
          chk("rr.gnt1", int'(gnt1), int'(own));
        end
        1: begin
          chk("rr.done0", int'(done0), int'(!own));
          chk("rr.done1", int'(done1), int'(own));
          chk("rr.result", int'(result), int'(own ? ref_shift(a1, b1) : ref_shift(a0, b0)));
          if (own) req1 = 1'b0; else req0 = 1'b0;
        end
        default: begin
          chk("rr.gap_busy", int'(busy), 0);
          chk("rr.gap_gnt", int'(gnt0 | gnt1), 0);
          if (c == 11) begin
            req0 = 1'b0; req1 = 1'b0;
          end else if (own) req1 = 1'b1;
          else req0 = 1'b1;
        end
      endcase
    end
    last_m = 1'b1;
    @(negedge clk);
    chk_idle("rr.end");

    // Operand change and req drop during BUSY must not disturb the operation.
    run_op(1'b1, 1'b0, 6'b101100, 6'd2, 6'h00, 6'h00, 1'b0, 6'b111011, 1'b1, "latch");

    // Randomized transactions checked against the reference model.
    for (int i = 0; i < 150; i++) begin
      r   = int'($urandom_range(1, 3));
      r0  = r[0];
      r1  = r[1];
      ra0 = 6'($urandom); ra1 = 6'($urandom);
      rb0 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      rb1 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      own = (r0 && r1) ? ~last_m : r1;
      keep = own ? ref_shift(ra1, rb1) : ref_shift(ra0, rb0);
      run_op(r0, r1, ra0, rb0, ra1, rb1, own, keep, 1'($urandom_range(0, 1)), "rand");
    end

    // Reset during BUSY abandons the op; last returns to 1 so requester 0 wins the tie.
    run_op(1'b0, 1'b1, 6'h00, 6'h00, 6'b011000, 6'd3, ~last_m & 1'b1 | 1'b1, 6'b000011, 1'b0, "pre");
    req0 = 1'b1; a0 = 6'b101100; b0 = 6'd1;
    @(negedge clk);
    chk("rb.busy", int'(busy), 1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk_idle("rb.rst");
    chk("rb.result", int'(result), 0);
    rst = 1'b0;
    last_m = 1'b1;
    @(negedge clk);
    chk_idle("rb.after");
    run_op(1'b1, 1'b1, 6'b010100, 6'd2, 6'b111000, 6'd1, 1'b0, 6'b000101, 1'b0, "rb.tie");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
